// File: rtl/mem_stage.sv
// mem_stage: EX/MEM and MEM/WB pipeline registers, sub-word load extraction and single-cycle read-modify-write stores.
module mem_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [3:0]            i_mem_op,
  input  logic [DATA_WIDTH-1:0] i_alu_res,
  input  logic [DATA_WIDTH-1:0] i_store_data,
  input  logic [4:0]            i_rd,
  input  logic                  i_reg_we,
  output logic [ADDR_WIDTH-1:0] o_dm_addr,
  output logic [DATA_WIDTH-1:0] o_dm_data,
  output logic                  o_dm_we,
  input  logic [DATA_WIDTH-1:0] i_dm_data,
  output logic [4:0]            o_mem_rd,
  output logic                  o_mem_reg_we,
  output logic                  o_mem_is_load,
  output logic [DATA_WIDTH-1:0] o_wb_data,
  output logic [4:0]            o_wb_rd,
  output logic                  o_wb_reg_we,
  output logic                  o_wb_exc
);
  localparam logic [3:0] OP_NONE = 4'd0, OP_LW = 4'd1, OP_LH = 4'd2, OP_LHU = 4'd3,
                         OP_LB = 4'd4, OP_LBU = 4'd5, OP_SW = 4'd6, OP_SH = 4'd7, OP_SB = 4'd8;
  logic [3:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] alu_q, alu_d, sd_q, sd_d;
  logic [4:0]            rd_q, rd_d;
  logic                  we_q, we_d, done_q, done_d;
  logic [DATA_WIDTH-1:0] wb_data_q, wb_data_d;
  logic [4:0]            wb_rd_q, wb_rd_d;
  logic                  wb_we_q, wb_we_d, wb_exc_q, wb_exc_d;
  logic                  is_ld, is_st, mis;
  logic [7:0]            byte_v;
  logic [15:0]           half_v;
  logic [DATA_WIDTH-1:0] res, wdata;
  always_comb begin
    is_ld = op_q >= OP_LW && op_q <= OP_LBU;
    is_st = op_q >= OP_SW && op_q <= OP_SB;
    mis = ((op_q == OP_LW || op_q == OP_SW) && alu_q[1:0] != 2'd0) ||
          ((op_q == OP_LH || op_q == OP_LHU || op_q == OP_SH) && alu_q[0]);
    byte_v = i_dm_data[8*alu_q[1:0] +: 8];
    half_v = alu_q[1] ? i_dm_data[31:16] : i_dm_data[15:0];
    res = op_q == OP_LW  ? i_dm_data :
          op_q == OP_LH  ? {{16{half_v[15]}}, half_v} :
          op_q == OP_LHU ? {16'd0, half_v} :
          op_q == OP_LB  ? {{24{byte_v[7]}}, byte_v} :
          op_q == OP_LBU ? {24'd0, byte_v} : alu_q;
    // sub-word stores merge into the word currently read back from memory
    wdata = op_q == OP_SW ? sd_q : i_dm_data;
    if (op_q == OP_SH) wdata[16*alu_q[1] +: 16] = sd_q[15:0];
    if (op_q == OP_SB) wdata[8*alu_q[1:0] +: 8] = sd_q[7:0];
    o_dm_we = is_st && !mis && !done_q;
    op_d   = i_flush ? OP_NONE : i_stall ? op_q  : i_mem_op;
    alu_d  = i_flush ? '0      : i_stall ? alu_q : i_alu_res;
    sd_d   = i_flush ? '0      : i_stall ? sd_q  : i_store_data;
    rd_d   = i_flush ? 5'd0    : i_stall ? rd_q  : i_rd;
    we_d   = i_flush ? 1'b0    : i_stall ? we_q  : i_reg_we;
    done_d = (i_flush || !i_stall) ? 1'b0 : done_q || o_dm_we;
    wb_data_d = i_stall ? wb_data_q : res;
    wb_rd_d   = i_stall ? wb_rd_q   : rd_q;
    wb_we_d   = i_stall ? wb_we_q   : we_q && !mis && !is_st;
    wb_exc_d  = i_stall ? wb_exc_q  : mis;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      op_q   <= OP_NONE;
      alu_q  <= '0;
      sd_q   <= '0;
      rd_q   <= 5'd0;
      we_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      alu_q  <= alu_d;
      sd_q   <= sd_d;
      rd_q   <= rd_d;
      we_q   <= we_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wb_data_q <= '0;
      wb_rd_q   <= 5'd0;
      wb_we_q   <= 1'b0;
      wb_exc_q  <= 1'b0;
    end else begin
      wb_data_q <= wb_data_d;
      wb_rd_q   <= wb_rd_d;
      wb_we_q   <= wb_we_d;
      wb_exc_q  <= wb_exc_d;
    end
  end
  assign o_dm_addr     = alu_q[ADDR_WIDTH+1:2];
  assign o_dm_data     = wdata;
  assign o_mem_rd      = rd_q;
  assign o_mem_reg_we  = we_q && !mis && !is_st;
  assign o_mem_is_load = is_ld;
  assign o_wb_data     = wb_data_q;
  assign o_wb_rd       = wb_rd_q;
  assign o_wb_reg_we   = wb_we_q;
  assign o_wb_exc      = wb_exc_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vectors for mem_stage against a 32-word memory model.
module tb_mem_stage;
  localparam logic [3:0] NONE = 4'd0, LW = 4'd1, LH = 4'd2, LHU = 4'd3,
                         LB = 4'd4, LBU = 4'd5, SW = 4'd6, SH = 4'd7, SB = 4'd8;
  logic        i_clk = 1'b0, i_rst_n = 1'b0, i_stall = 1'b0, i_flush = 1'b0;
  logic [3:0]  i_mem_op = NONE;
  logic [31:0] i_alu_res = '0, i_store_data = '0, i_dm_data, o_dm_data, o_wb_data;
  logic [4:0]  i_rd = '0, o_dm_addr, o_mem_rd, o_wb_rd;
  logic        i_reg_we = 1'b0, o_dm_we, o_mem_reg_we, o_mem_is_load, o_wb_reg_we, o_wb_exc;
  logic [31:0] mem [32];
  int          checks = 0, errors = 0;

  mem_stage dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_mem_op(i_mem_op), .i_alu_res(i_alu_res), .i_store_data(i_store_data),
    .i_rd(i_rd), .i_reg_we(i_reg_we), .o_dm_addr(o_dm_addr), .o_dm_data(o_dm_data),
    .o_dm_we(o_dm_we), .i_dm_data(i_dm_data), .o_mem_rd(o_mem_rd),
    .o_mem_reg_we(o_mem_reg_we), .o_mem_is_load(o_mem_is_load), .o_wb_data(o_wb_data),
    .o_wb_rd(o_wb_rd), .o_wb_reg_we(o_wb_reg_we), .o_wb_exc(o_wb_exc)
  );

  always #5 i_clk = ~i_clk;
  assign i_dm_data = mem[o_dm_addr];
  always @(posedge i_clk) if (o_dm_we) mem[o_dm_addr] = o_dm_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic we);
    i_mem_op = op; i_alu_res = a; i_store_data = d; i_rd = rd; i_reg_we = we;
    step();
  endtask

  task automatic load_chk(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] exp);
    issue(op, a, 32'h0, 5'd3, 1'b1);
    issue(NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    check(tag, o_wb_data, exp);
    check({tag, "_we"}, {31'd0, o_wb_reg_we}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hDEAD0000 + i;
    mem[0] = 32'hDEADBEEF;
    mem[1] = 32'h11223344;
    #12 i_rst_n = 1'b1;
    // store in flight, reset asserted mid-cycle
    issue(SW, 32'h0, 32'h55, 5'd0, 1'b0);
    check("rst_pre_we", {31'd0, o_dm_we}, 32'd1);
    i_mem_op = NONE;
    #2 i_rst_n = 1'b0;
    #1;
    check("rst_we", {31'd0, o_dm_we}, 32'd0);
    check("rst_wb_data", o_wb_data, 32'd0);
    check("rst_wb_ctl", {o_wb_rd, o_wb_reg_we, o_wb_exc}, 32'd0);
    #2 i_rst_n = 1'b1;
    step();
    check("rst_abandon", mem[0], 32'hDEADBEEF);
    // SB read-modify-write
    issue(SB, 32'h6, 32'h000000AB, 5'd0, 1'b0);
    check("sb_addr", {27'd0, o_dm_addr}, 32'd1);
    check("sb_data", o_dm_data, 32'h11AB3344);
    check("sb_we", {31'd0, o_dm_we}, 32'd1);
    issue(NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    check("sb_we_off", {31'd0, o_dm_we}, 32'd0);
    check("sb_mem", mem[1], 32'h11AB3344);
    check("sb_wb_we", {31'd0, o_wb_reg_we}, 32'd0);
    // loads
    mem[1] = 32'h80FF7F01;
    load_chk("lb5", LB, 32'h5, 32'h0000007F);
    check("lb5_rd", {27'd0, o_wb_rd}, 32'd3);
    load_chk("lb6", LB, 32'h6, 32'hFFFFFFFF);
    load_chk("lbu6", LBU, 32'h6, 32'h000000FF);
    load_chk("lh6", LH, 32'h6, 32'hFFFF80FF);
    load_chk("lhu4", LHU, 32'h4, 32'h00007F01);
    load_chk("lw_wrap", LW, 32'h84, 32'h80FF7F01);
    issue(SH, 32'h6, 32'hFFFF1234, 5'd0, 1'b0);
    check("sh_data", o_dm_data, 32'h12347F01);
    issue(NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    check("sh_mem", mem[1], 32'h12347F01);
    // stalled SW writes exactly once
    issue(NONE, 32'h777, 32'h0, 5'd7, 1'b1);
    issue(SW, 32'h8, 32'hCAFEF00D, 5'd0, 1'b0);
    i_mem_op = NONE; i_stall = 1'b1;
    check("sw_we1", {31'd0, o_dm_we}, 32'd1);
    step();
    check("sw_mem", mem[2], 32'hCAFEF00D);
    check("sw_we2", {31'd0, o_dm_we}, 32'd0);
    mem[2] = 32'h0;
    step();
    check("sw_we3", {31'd0, o_dm_we}, 32'd0);
    check("stall_wb_data", o_wb_data, 32'h777);
    check("stall_wb_ctl", {26'd0, o_wb_rd, o_wb_reg_we}, {26'd0, 5'd7, 1'b1});
    step();
    i_stall = 1'b0;
    check("sw_once", mem[2], 32'h0);
    step();
    check("sw_adv_data", o_wb_data, 32'h8);
    check("sw_adv_we", {31'd0, o_wb_reg_we}, 32'd0);
    // misaligned accesses
    issue(LW, 32'h2, 32'h0, 5'd4, 1'b1);
    check("mis_lw_we", {31'd0, o_dm_we}, 32'd0);
    check("mis_lw_mem_we", {31'd0, o_mem_reg_we}, 32'd0);
    check("mis_lw_is_load", {31'd0, o_mem_is_load}, 32'd1);
    issue(NONE, 32'h55, 32'h0, 5'd5, 1'b1);
    check("mis_lw_exc", {30'd0, o_wb_exc, o_wb_reg_we}, 32'b10);
    issue(NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    check("mis_exc_clr", {30'd0, o_wb_exc, o_wb_reg_we}, 32'b01);
    check("mis_next_data", o_wb_data, 32'h55);
    issue(SH, 32'h3, 32'h0000BEEF, 5'd0, 1'b0);
    check("mis_sh_we", {31'd0, o_dm_we}, 32'd0);
    issue(NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    check("mis_sh_exc", {31'd0, o_wb_exc}, 32'd1);
    check("mis_sh_mem", mem[0], 32'hDEADBEEF);
    // flush and stall together
    issue(NONE, 32'h999, 32'h0, 5'd9, 1'b1);
    issue(NONE, 32'hAAA, 32'h0, 5'd10, 1'b1);
    i_flush = 1'b1; i_stall = 1'b1;
    issue(LW, 32'h4, 32'h0, 5'd11, 1'b1);
    i_flush = 1'b0; i_stall = 1'b0;
    check("fl_is_load", {31'd0, o_mem_is_load}, 32'd0);
    check("fl_mem_ctl", {26'd0, o_mem_rd, o_mem_reg_we}, 32'd0);
    check("fl_wb_data", o_wb_data, 32'h999);
    check("fl_wb_ctl", {26'd0, o_wb_rd, o_wb_reg_we}, {26'd0, 5'd9, 1'b1});
    issue(NONE, 32'h0, 32'h0, 5'd0, 1'b0);
    check("fl_bubble_wb", {o_wb_data[26:0], o_wb_rd}, 32'd0);
    check("fl_bubble_we", {31'd0, o_wb_reg_we}, 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
